// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with optional parity bit, a single-word
// holding register with valid/ready handoff, and a sticky overrun flag.
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1,
    parameter int PARITY    = 0,
    localparam int CW       = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_clr,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             parity_err,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic [CW-1:0]    bit_count
);

    localparam int N = (PARITY == 0) ? WIDTH : WIDTH + 1;

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] word_reg;
    logic             valid_reg;
    logic             perr_reg;
    logic             overrun_reg;

    logic             data_phase;
    logic             last_bit;
    logic             complete;
    logic             hold_free;
    logic [WIDTH-1:0] frame_word;
    logic             frame_perr;

    // Shift direction decides which end the newest bit enters.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (LSB_FIRST != 0) begin : g_lsb
                if (gi == WIDTH - 1) begin : g_top
                    assign shift_next[gi] = bit_in;
                end else begin : g_mid
                    assign shift_next[gi] = shift_reg[gi+1];
                end
            end else begin : g_msb
                if (gi == 0) begin : g_bot
                    assign shift_next[gi] = bit_in;
                end else begin : g_mid
                    assign shift_next[gi] = shift_reg[gi-1];
                end
            end
        end
    endgenerate

    assign data_phase = (count_reg < CW'(WIDTH));
    assign last_bit   = (count_reg == CW'(N - 1));
    assign complete   = bit_valid && !frame_clr && last_bit;
    assign hold_free  = !valid_reg || word_ready;

    // Without parity the completing bit is still data, so take the shifted value;
    // with parity the data is already complete and bit_in is the parity bit.
    generate
        if (PARITY == 0) begin : g_nopar
            assign frame_word = shift_next;
            assign frame_perr = 1'b0;
        end else begin : g_par
            assign frame_word = shift_reg;
            assign frame_perr = (^shift_reg) ^ bit_in ^ (PARITY == 2);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            count_reg   <= '0;
            word_reg    <= '0;
            valid_reg   <= 1'b0;
            perr_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (frame_clr) begin
                shift_reg <= '0;
                count_reg <= '0;
            end else if (bit_valid) begin
                if (last_bit) begin
                    shift_reg <= '0;
                    count_reg <= '0;
                end else begin
                    count_reg <= count_reg + CW'(1);
                    if (data_phase) begin
                        shift_reg <= shift_next;
                    end
                end
            end

            if (complete && hold_free) begin
                word_reg  <= frame_word;
                perr_reg  <= frame_perr;
                valid_reg <= 1'b1;
            end else if (valid_reg && word_ready) begin
                valid_reg <= 1'b0;
            end

            // A dropped frame wins over a coincident clear.
            if (complete && !hold_free) begin
                overrun_reg <= 1'b1;
            end else if (overrun_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign word_out   = word_reg;
    assign word_valid = valid_reg;
    assign parity_err = perr_reg;
    assign overrun    = overrun_reg;
    assign bit_count  = count_reg;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench: LSB-first and MSB-first instances share one bit stream,
// even/odd parity instances share a second stream.
module tb_sipo_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, bit_in, bit_valid, frame_clr, word_ready, overrun_clr;
    logic [7:0] word_out, m_word_out;
    logic       word_valid, m_word_valid, parity_err, m_parity_err, overrun, m_overrun;
    logic [3:0] bit_count, m_bit_count;

    logic       p_bit_in, p_bit_valid, p_ready;
    logic [7:0] e_word, o_word;
    logic       e_valid, o_valid, e_perr, o_perr, e_ovr, o_ovr;
    logic [3:0] e_cnt, o_cnt;

    sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1), .PARITY(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_clr(frame_clr), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .parity_err(parity_err), .overrun(overrun),
        .overrun_clr(overrun_clr), .bit_count(bit_count));

    sipo_deserializer #(.WIDTH(8), .LSB_FIRST(0), .PARITY(0)) u_msb (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_clr(frame_clr), .word_out(m_word_out), .word_valid(m_word_valid),
        .word_ready(word_ready), .parity_err(m_parity_err), .overrun(m_overrun),
        .overrun_clr(overrun_clr), .bit_count(m_bit_count));

    sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1), .PARITY(1)) u_even (
        .clk(clk), .rst_n(rst_n), .bit_in(p_bit_in), .bit_valid(p_bit_valid),
        .frame_clr(frame_clr), .word_out(e_word), .word_valid(e_valid),
        .word_ready(p_ready), .parity_err(e_perr), .overrun(e_ovr),
        .overrun_clr(overrun_clr), .bit_count(e_cnt));

    sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1), .PARITY(2)) u_odd (
        .clk(clk), .rst_n(rst_n), .bit_in(p_bit_in), .bit_valid(p_bit_valid),
        .frame_clr(frame_clr), .word_out(o_word), .word_valid(o_valid),
        .word_ready(p_ready), .parity_err(o_perr), .overrun(o_ovr),
        .overrun_clr(overrun_clr), .bit_count(o_cnt));

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_m_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = v[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // seq[i] is the i-th bit on the wire; gaps inserts random idle cycles.
    task automatic send_frame(input logic [7:0] seq, input bit deliver,
                              input bit ready_last, input bit gaps);
        if (deliver) begin
            exp_q.push_back(seq);
            exp_m_q.push_back(rev8(seq));
        end
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                int idle = $urandom_range(0, 2);
                for (int k = 0; k < idle; k++) tick();
            end
            bit_in     = seq[i];
            bit_valid  = 1'b1;
            word_ready = ready_last && (i == 7);
            if (word_ready && word_valid && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(exp_m_q.pop_front());
            end
            tick();
            bit_valid  = 1'b0;
            word_ready = 1'b0;
            if (i < 7) check("bit_count", bit_count, i + 1);
            else       check("bit_count_wrap", bit_count, 0);
        end
    endtask

    task automatic expect_word(input string tag);
        check({tag, "_valid"}, word_valid, 1);
        check({tag, "_m_valid"}, m_word_valid, 1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            check({tag, "_word"}, word_out, exp_q[0]);
            check({tag, "_m_word"}, m_word_out, exp_m_q[0]);
        end
        check({tag, "_perr"}, parity_err, 0);
    endtask

    task automatic consume(input string tag);
        logic [7:0] held;
        held = word_out;
        if (exp_q.size() > 0) begin
            held = exp_q.pop_front();
            void'(exp_m_q.pop_front());
        end
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check({tag, "_valid_clr"}, word_valid, 0);
        check({tag, "_hold"}, word_out, held);
    endtask

    task automatic psend(input logic [7:0] d, input logic p);
        logic exp_even;
        for (int i = 0; i < 9; i++) begin
            p_bit_in    = (i < 8) ? d[i] : p;
            p_bit_valid = 1'b1;
            tick();
        end
        p_bit_valid = 1'b0;
        exp_even = (^d) ^ p;
        $display("[TB] parity frame data=%02h p=%0d", d, p);
        check("par_valid", e_valid, 1);
        check("par_word_even", e_word, d);
        check("par_word_odd", o_word, d);
        check("par_cnt", e_cnt, 0);
        check("perr_even", e_perr, exp_even);
        check("perr_odd", o_perr, !exp_even);
        p_ready = 1'b1;
        tick();
        p_ready = 1'b0;
        check("par_valid_clr", o_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; frame_clr = 1'b0;
        word_ready = 1'b0; overrun_clr = 1'b0;
        p_bit_in = 1'b0; p_bit_valid = 1'b0; p_ready = 1'b0;
        tick();
        tick();
        check("rst_word", word_out, 0);
        check("rst_valid", word_valid, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_cnt", bit_count, 0);
        rst_n = 1'b1;
        tick();

        // Bits 1,1,0,0,0,0,0,0 -> 8'h03 LSB-first, 8'hC0 MSB-first.
        $display("[TB] frame 03, held without ready");
        send_frame(8'h03, 1, 0, 0);
        expect_word("f03");
        check("f03_literal", word_out, 8'h03);
        check("f03_m_literal", m_word_out, 8'hC0);

        $display("[TB] frame FF while holding -> overrun");
        send_frame(8'hFF, 0, 0, 0);
        expect_word("ovr");
        check("ovr_set", overrun, 1);
        check("ovr_m_set", m_overrun, 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clr", overrun, 0);

        $display("[TB] frame 55 with ready on completion edge");
        send_frame(8'h55, 1, 1, 0);
        expect_word("f55");
        check("f55_ovr", overrun, 0);
        consume("f55");

        $display("[TB] frame_clr after 5 bits, then A5");
        for (int i = 0; i < 5; i++) begin
            bit_in = 1'b1; bit_valid = 1'b1;
            tick();
        end
        check("pre_clr_cnt", bit_count, 5);
        frame_clr = 1'b1;
        tick();
        frame_clr = 1'b0; bit_valid = 1'b0;
        check("clr_cnt", bit_count, 0);
        check("clr_valid", word_valid, 0);
        send_frame(8'hA5, 1, 0, 0);
        expect_word("fA5");
        consume("fA5");

        psend(8'h03, 1'b0);
        psend(8'h03, 1'b1);
        psend(8'h5B, 1'b0);

        $display("[TB] random frames with idle gaps");
        for (int n = 0; n < 4; n++) begin
            r = 8'($urandom);
            send_frame(r, 1, 0, 1);
            expect_word("rnd");
            consume("rnd");
        end

        $display("[TB] reset mid-handshake and mid-frame");
        send_frame(8'h3C, 1, 0, 0);
        expect_word("f3C");
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'b1; bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("mrst_word", word_out, 0);
        check("mrst_valid", word_valid, 0);
        check("mrst_perr", parity_err, 0);
        check("mrst_ovr", overrun, 0);
        check("mrst_cnt", bit_count, 0);
        rst_n = 1'b1;
        exp_q.delete();
        exp_m_q.delete();
        send_frame(8'h81, 1, 0, 0);
        expect_word("f81");
        consume("f81");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
